// File: rtl/ro_edge_meter.sv
// Ring-oscillator edge meter: counts synchronised rising edges of ro_in over a gate window.
// Define RO_EDGE_METER_CONT_EN for continuous back-to-back windows after the first start.
module ro_edge_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             overflow
);

    localparam int TW = $clog2(GATE_CYCLES + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    typedef enum logic {IDLE, GATE} state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic sync_d;
    logic rise;
    logic [TW-1:0] timer, timer_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, result_nx;
    logic sat, sat_nx, ovf_nx, done_nx;

    assign rise = sync[SYNC_STAGES-1] & ~sync_d;
    assign busy = (state == GATE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], ro_in};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        cnt_nx    = cnt;
        sat_nx    = sat;
        result_nx = result;
        ovf_nx    = overflow;
        done_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                // an edge seen in the start cycle is deliberately dropped
                if (start) begin
                    state_nx = GATE;
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                    timer_nx = T_LOAD;
                end
            end
            GATE: begin
                if (rise) begin
                    if (cnt == C_MAX)
                        sat_nx = 1'b1;
                    else
                        cnt_nx = cnt + 1'b1;
                end
                if (timer == '0) begin
                    result_nx = cnt_nx;
                    ovf_nx    = sat_nx;
                    done_nx   = 1'b1;
`ifdef RO_EDGE_METER_CONT_EN
                    cnt_nx    = '0;
                    sat_nx    = 1'b0;
                    timer_nx  = T_LOAD;
`else
                    state_nx  = IDLE;
`endif
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            cnt      <= cnt_nx;
            sat      <= sat_nx;
            result   <= result_nx;
            overflow <= ovf_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_ro_edge_meter.sv
// Scoreboard bench for ro_edge_meter: expected counts come from the driven ro_in
// waveform (rising transitions whose synchronised detection falls inside the gate).
module tb_ro_edge_meter;

    localparam int GS = 100;
    localparam int GL = 1000;
    localparam int LAT = 2;

    typedef struct {
        int res;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ro_s = 1'b0, st_s = 1'b0, ro_l = 1'b0, st_l = 1'b0;
    logic busy_s, done_s, ovf_s, busy_l, done_l, ovf_l;
    logic [7:0] res_s, res_l;

    int n_chk = 0;
    int n_fail = 0;
    exp_t q_s[$];
    exp_t q_l[$];
    exp_t e_s, e_l;
    bit wave[0:1199];
    bit p1[2];
    bit p2[2];
    int busy_run[2];

    always #5 clk = ~clk;

    ro_edge_meter #(.GATE_CYCLES(GS), .CNT_W(8), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .reset(reset), .ro_in(ro_s), .start(st_s),
        .busy(busy_s), .done(done_s), .result(res_s), .overflow(ovf_s)
    );

    ro_edge_meter #(.GATE_CYCLES(GL), .CNT_W(8), .SYNC_STAGES(2)) dut_l (
        .clk(clk), .reset(reset), .ro_in(ro_l), .start(st_l),
        .busy(busy_l), .done(done_l), .result(res_l), .overflow(ovf_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit ro, input bit st);
        if (d == 0) begin
            ro_s = ro;
            st_s = st;
        end else begin
            ro_l = ro;
            st_l = st;
        end
        p2[d] = p1[d];
        p1[d] = ro;
    endtask

    task automatic idle_cycles(input int d, input bit v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive(d, v, 1'b0);
        end
    endtask

    // wave[i] is driven after clock edge c0+i; start is driven with wave[0],
    // so a rise first seen at sample j is counted iff -1 <= j <= g-LAT-... (g-2).
    task automatic measure(input int d, input int np, input int hi, input int lo,
                           input int dly, input int tail, input int restart_at);
        int g, len, pos, cnt;
        bit ovf, prv, cur;
        exp_t e;
        g = (d == 0) ? GS : GL;
        len = g + tail;
        for (int i = 0; i < len; i++) wave[i] = p1[d];
        pos = dly;
        for (int k = 0; k < np; k++) begin
            for (int h = 0; h < hi; h++) begin
                if (pos < len) wave[pos] = 1'b1;
                pos++;
            end
            for (int l = 0; l < lo; l++) begin
                if (pos < len) wave[pos] = 1'b0;
                pos++;
            end
        end
        cnt = 0;
        ovf = 1'b0;
        prv = p2[d];
        for (int j = -1; j <= g - LAT; j++) begin
            cur = (j < 0) ? p1[d] : wave[j];
            if (cur && !prv) begin
                if (cnt == 255) ovf = 1'b1;
                else cnt++;
            end
            prv = cur;
        end
        e.res = cnt;
        e.ovf = ovf;
        if (d == 0) q_s.push_back(e);
        else q_l.push_back(e);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            drive(d, wave[i], (i == 0) || (i == restart_at));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            busy_run[0] = 0;
            busy_run[1] = 0;
        end else begin
            if (busy_s) busy_run[0]++;
            if (busy_l) busy_run[1]++;
            if (done_s) begin
                chk("busy_len_s", busy_run[0], GS);
                busy_run[0] = 0;
                if (q_s.size() == 0) begin
                    chk("unexpected_done_s", 1, 0);
                end else begin
                    e_s = q_s.pop_front();
                    chk("result_s", res_s, e_s.res);
                    chk("overflow_s", ovf_s, e_s.ovf);
                end
            end
            if (done_l) begin
                chk("busy_len_l", busy_run[1], GL);
                busy_run[1] = 0;
                if (q_l.size() == 0) begin
                    chk("unexpected_done_l", 1, 0);
                end else begin
                    e_l = q_l.pop_front();
                    chk("result_l", res_l, e_l.res);
                    chk("overflow_l", ovf_l, e_l.ovf);
                end
            end
        end
    end

    initial begin
        int hi, lo, np, dly, tail;
        p1 = '{0, 0};
        p2 = '{0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_result", res_s, 0);
        chk("rst_overflow", ovf_s, 0);
        idle_cycles(0, 1'b0, 4);

        measure(0, 25, 2, 2, 2, 6, -1);
        idle_cycles(0, 1'b1, 6);
        measure(0, 0, 1, 1, 0, 6, -1);
        idle_cycles(0, 1'b0, 6);
        measure(0, 20, 2, 3, 4, 6, 50);
        idle_cycles(0, 1'b0, 4);

        for (int r = 0; r < 8; r++) begin
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 4);
            np = $urandom_range(0, 40);
            dly = $urandom_range(0, 8);
            tail = (r % 2 == 0) ? 1 : $urandom_range(2, 6);
            measure(0, np, hi, lo, dly, tail, -1);
        end
        idle_cycles(0, 1'b0, 6);

        measure(1, 300, 2, 1, 2, 5, -1);
        idle_cycles(1, 1'b0, 4);
        measure(1, 10, 2, 2, 3, 5, -1);
        idle_cycles(1, 1'b0, 4);

        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1);
        repeat (40) begin
            @(posedge clk);
            #1 drive(0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_s, 0);
        chk("abort_done", done_s, 0);
        chk("abort_result", res_s, 0);
        chk("abort_overflow", ovf_s, 0);
        chk("abort_result_l", res_l, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        p1 = '{0, 0};
        p2 = '{0, 0};
        idle_cycles(0, 1'b0, 4);
        measure(0, 7, 2, 2, 5, 6, -1);

        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (q_s.size() == 0 && q_l.size() == 0) break;
        end
        chk("queue_drained", q_s.size() + q_l.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
